// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operation sequencer.
// Holds the sequencer state encoding, the bit positions inside the 5-bit
// ALU flag vector, and the ALU op-code values passed through by the sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  // Bit positions inside alu_flags / rsp_flags
  localparam int FLG_PARITY = 4;
  localparam int FLG_OVF    = 3;
  localparam int FLG_GT     = 2;
  localparam int FLG_LT     = 1;
  localparam int FLG_EQ     = 0;

  // ALU op codes (carried through untouched by the sequencer)
  localparam logic [1:0] ALU_OP_ADD = 2'd0;
  localparam logic [1:0] ALU_OP_SUB = 2'd1;
  localparam logic [1:0] ALU_OP_AND = 2'd2;
  localparam logic [1:0] ALU_OP_CMP = 2'd3;

  // Width of the ALU latency down-counter
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: two-input round-robin arbiter.
// The grant is purely combinational from req_i and last_grant_q; on a tie the
// requester that did not win last time is granted. last_grant_q resets to 1 so
// requester 0 wins the first tie. The caller masks req_i when it cannot accept.
module alu_rr_arb2
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_grant_q;

  // Grant selection: single requester wins outright, a tie goes to the other side
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Remember who was granted so the next tie flips
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (|gnt_o) begin
      last_grant_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: shares one ALU between two requesters.
// Round-robin arbitration in IDLE, operands held on the ALU for ALU_LAT cycles
// in ISSUE, result/flags captured and returned over a valid/ready channel in
// RESP. No arithmetic happens here; y and flags pass through untouched.
// Optional: define ALU_SEQ_STATS_EN to add per-requester op counters and a
// response-stall cycle counter (stat_ops0, stat_ops1, stat_stall).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [4:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic [4:0]       rsp_flags
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]      stat_ops0,
  output logic [15:0]      stat_ops1,
  output logic [15:0]      stat_stall
`endif
);

  // ISSUE lasts ALU_LAT cycles: the counter starts at ALU_LAT-1 and captures at 0
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(ALU_LAT - 1);

  seq_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;
  logic [1:0]           alu_op_q, alu_op_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic                 id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_y_q, rsp_y_d;
  logic [4:0]           rsp_flags_q, rsp_flags_d;

  logic                 accept_en;
  logic [1:0]           arb_req;
  logic [1:0]           gnt;

  // Requests are only offered to the arbiter while idle and out of reset
  assign accept_en = (state_q == IDLE) && !rst;
  assign arb_req   = {req1_valid, req0_valid} & {2{accept_en}};

  alu_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (arb_req),
    .gnt_o (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Next-state and datapath capture decisions for the IDLE/ISSUE/RESP sequence
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          if (gnt[1]) begin
            alu_op_d = req1_op;
            alu_a_d  = req1_a;
            alu_b_d  = req1_b;
          end else begin
            alu_op_d = req0_op;
            alu_a_d  = req0_a;
            alu_b_d  = req0_b;
          end
          id_d    = gnt[1];
          lat_d   = LAT_INIT;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          rsp_y_d     = alu_y;
          rsp_flags_d = alu_flags;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        // Retirement cycle never accepts: IDLE is entered on the next edge
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and response registers; reset drops any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops0_q, stat_ops1_q, stat_stall_q;

  // Wrapping counters: accepted ops per requester and back-pressured RESP cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops0_q  <= '0;
      stat_ops1_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (req0_valid && req0_ready) stat_ops0_q <= stat_ops0_q + 16'd1;
      if (req1_valid && req1_ready) stat_ops1_q <= stat_ops1_q + 16'd1;
      if ((state_q == RESP) && !rsp_ready) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_ops0  = stat_ops0_q;
  assign stat_ops1  = stat_ops1_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a scoreboarded ALU_LAT=1 instance with a
// behavioural ALU, plus an ALU_LAT=4 instance fed by a per-cycle ramp for
// latency and mid-ISSUE reset checks. Stats checks appear when
// ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } stim_t;

  typedef struct packed {
    logic       id;
    logic [7:0] y;
    logic [4:0] flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A (ALU_LAT=1) ----------------
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [4:0] alu_flags;
  logic       rsp_valid, rsp_id;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_y;
  logic [4:0] rsp_flags;

  // ---------------- instance B (ALU_LAT=4) ----------------
  logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic       b_req0_ready, b_req1_ready;
  logic [1:0] b_req0_op = '0, b_req1_op = '0;
  logic [7:0] b_req0_a = '0, b_req0_b = '0, b_req1_a = '0, b_req1_b = '0;
  logic [1:0] b_alu_op;
  logic [7:0] b_alu_a, b_alu_b, b_alu_y;
  logic [4:0] b_alu_flags;
  logic       b_rsp_valid, b_rsp_id;
  logic       b_rsp_ready = 1'b1;
  logic [7:0] b_rsp_y;
  logic [4:0] b_rsp_flags;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops0, stat_ops1, stat_stall;
  logic [15:0] b_stat_ops0, b_stat_ops1, b_stat_stall;
`endif

  // Behavioural ALU: returns {parity, ovf, gt, lt, eq, y}
  function automatic logic [12:0] alu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    logic ovf, gt, lt, eq;
    y = '0; ovf = 1'b0; gt = 1'b0; lt = 1'b0; eq = 1'b0;
    case (op)
      2'd0: begin y = a + b; ovf = (a[7] == b[7]) && (y[7] != a[7]); end
      2'd1: begin y = a - b; ovf = (a[7] != b[7]) && (y[7] != a[7]); end
      2'd2: y = a & b;
      default: begin gt = (a > b); lt = (a < b); eq = (a == b); end
    endcase
    return {^y, ovf, gt, lt, eq, y};
  endfunction

  logic [12:0] alu_res;
  assign alu_res     = alu_model(alu_op, alu_a, alu_b);
  assign alu_y       = alu_res[7:0];
  assign alu_flags   = alu_res[12:8];
  assign b_alu_y     = cyc[7:0];
  assign b_alu_flags = cyc[4:0];

  alu_op_sequencer #(.WIDTH(8), .ALU_LAT(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_flags  (rsp_flags)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops0  (stat_ops0),
    .stat_ops1  (stat_ops1),
    .stat_stall (stat_stall)
`endif
  );

  alu_op_sequencer #(.WIDTH(8), .ALU_LAT(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (b_req0_valid),
    .req0_ready (b_req0_ready),
    .req0_op    (b_req0_op),
    .req0_a     (b_req0_a),
    .req0_b     (b_req0_b),
    .req1_valid (b_req1_valid),
    .req1_ready (b_req1_ready),
    .req1_op    (b_req1_op),
    .req1_a     (b_req1_a),
    .req1_b     (b_req1_b),
    .alu_op     (b_alu_op),
    .alu_a      (b_alu_a),
    .alu_b      (b_alu_b),
    .alu_y      (b_alu_y),
    .alu_flags  (b_alu_flags),
    .rsp_valid  (b_rsp_valid),
    .rsp_ready  (b_rsp_ready),
    .rsp_id     (b_rsp_id),
    .rsp_y      (b_rsp_y),
    .rsp_flags  (b_rsp_flags)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops0  (b_stat_ops0),
    .stat_ops1  (b_stat_ops1),
    .stat_stall (b_stat_stall)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard and bookkeeping
  stim_t s0_q[$], s1_q[$];
  exp_t  exp_q[$];
  int    glog[$];
  logic  acc0 = 1'b0, acc1 = 1'b0, prev_acc = 1'b0, rsp_v_prev = 1'b0;
  int    acc_cnt = 0, rsp_cnt = 0, viol = 0;
  int    last_acc_cyc = 0, last_rsp_cyc = 0, rise_cyc = 0;

  // Requester drivers for instance A; acceptance pushes the expected response
  always @(negedge clk) begin
    exp_t        e;
    logic [12:0] m;
    if (acc0 && s0_q.size() > 0) void'(s0_q.pop_front());
    if (acc1 && s1_q.size() > 0) void'(s1_q.pop_front());
    if (s0_q.size() > 0) begin
      req0_valid = 1'b1;
      {req0_op, req0_a, req0_b} = s0_q[0];
    end else begin
      req0_valid = 1'b0;
    end
    if (s1_q.size() > 0) begin
      req1_valid = 1'b1;
      {req1_op, req1_a, req1_b} = s1_q[0];
    end else begin
      req1_valid = 1'b0;
    end
    #1;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if ((req0_ready || req1_ready) && (rsp_valid || prev_acc)) viol++;
    if (req0_ready && req1_ready) viol++;
    if (req0_ready && !req0_valid) viol++;
    if (req1_ready && !req1_valid) viol++;
    prev_acc = acc0 || acc1;
    if (acc0) begin
      m = alu_model(req0_op, req0_a, req0_b);
      e.id = 1'b0; e.y = m[7:0]; e.flags = m[12:8];
      exp_q.push_back(e);
      glog.push_back(0);
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    if (acc1) begin
      m = alu_model(req1_op, req1_a, req1_b);
      e.id = 1'b1; e.y = m[7:0]; e.flags = m[12:8];
      exp_q.push_back(e);
      glog.push_back(1);
      acc_cnt++;
      last_acc_cyc = cyc;
    end
  end

  // Response monitor for instance A
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rsp_valid && !rsp_v_prev) rise_cyc = cyc;
    rsp_v_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_y", 32'(rsp_y), 32'(e.y));
        chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
      end
      rsp_cnt++;
      last_rsp_cyc = cyc;
    end
  end

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 100) begin
      @(negedge clk); #3; n++;
    end
    if (acc_cnt < target) chk("acc_timeout", 32'(acc_cnt), 32'(target));
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 200) begin
      @(negedge clk); #3; n++;
    end
    if (rsp_cnt < target) chk("rsp_timeout", 32'(rsp_cnt), 32'(target));
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    do begin
      @(negedge clk); #3; n++;
    end while (!rsp_valid && n < 50);
    if (!rsp_valid) chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int         a0, a1, r0, c0, n, cnt;
    logic [7:0] y0;
    logic [4:0] f0;
    logic [31:0] ev;

    // Reset state, with a request presented during reset
    repeat (2) @(negedge clk);
    b_req0_valid = 1'b1;
    #3;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_alu_opab", 32'({alu_op, alu_a, alu_b}), 32'd0);
    chk("rst_ready_held", 32'(b_req0_ready), 32'd0);
    @(negedge clk); b_req0_valid = 1'b0; rst = 1'b0;

    // Single op: 5 + 3
    a0 = acc_cnt; r0 = rsp_cnt;
    s0_q.push_back('{op: 2'd0, a: 8'h05, b: 8'h03});
    wait_acc(a0 + 1);
    @(negedge clk); #3;
    chk("alu_a_T1", 32'(alu_a), 32'h05);
    chk("alu_b_T1", 32'(alu_b), 32'h03);
    wait_rsp(r0 + 1);
    chk("lat1_rsp", 32'(rise_cyc - last_acc_cyc), 32'd2);

    // Tie arbitration after fresh reset: grant order 0,1,0,1
    pulse_rst();
    glog.delete();
    r0 = rsp_cnt;
    s0_q.push_back('{op: 2'd1, a: 8'h80, b: 8'h01});
    s0_q.push_back('{op: 2'd3, a: 8'h10, b: 8'h10});
    s1_q.push_back('{op: 2'd0, a: 8'h7F, b: 8'h01});
    s1_q.push_back('{op: 2'd2, a: 8'hF0, b: 8'h3C});
    wait_rsp(r0 + 4);
    chk("tie_count", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), 32'(glog[i]), 32'(i % 2));
    end

    // Backpressure: response held 5 cycles, pending req1 not granted
    @(negedge clk); rsp_ready = 1'b0;
    a0 = acc_cnt; r0 = rsp_cnt;
    s0_q.push_back('{op: 2'd0, a: 8'h22, b: 8'h11});
    wait_rsp_valid();
    s1_q.push_back('{op: 2'd1, a: 8'h05, b: 8'h09});
    y0 = rsp_y; f0 = rsp_flags; a1 = acc_cnt;
    chk("bp_first_acc", 32'(a1), 32'(a0 + 1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_y_stable", 32'(rsp_y), 32'(y0));
      chk("bp_flags_stable", 32'(rsp_flags), 32'(f0));
    end
    chk("bp_no_grant", 32'(acc_cnt), 32'(a1));
    @(negedge clk); rsp_ready = 1'b1;
    wait_acc(a1 + 1);
    chk("bp_regrant", 32'(last_acc_cyc - last_rsp_cyc), 32'd1);
    wait_rsp(r0 + 2);

    // ALU_LAT=4 with a ramping ALU output
    @(negedge clk);
    b_req0_valid = 1'b1; b_req0_op = 2'd0; b_req0_a = 8'h12; b_req0_b = 8'h34;
    #1;
    chk("lat4_ready", 32'(b_req0_ready), 32'd1);
    c0 = cyc;
    @(negedge clk); b_req0_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (!b_rsp_valid && n < 20);
    ev = 32'(c0 + 4);
    chk("lat4_latency", 32'(cyc - c0), 32'd5);
    chk("lat4_y", 32'(b_rsp_y), 32'(ev[7:0]));
    chk("lat4_flags", 32'(b_rsp_flags), 32'(ev[4:0]));
    chk("lat4_id", 32'(b_rsp_id), 32'd0);

    // Reset pulse in the middle of ISSUE aborts the op
    repeat (2) @(negedge clk);
    b_req1_valid = 1'b1; b_req1_op = 2'd0; b_req1_a = 8'hAA; b_req1_b = 8'h01;
    #1;
    chk("abort_ready1", 32'(b_req1_ready), 32'd1);
    @(negedge clk); b_req1_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("abort_alu_a", 32'(b_alu_a), 32'd0);
    chk("abort_alu_op", 32'(b_alu_op), 32'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (b_rsp_valid) cnt++;
    end
    chk("abort_no_rsp", 32'(cnt), 32'd0);

`ifdef ALU_SEQ_STATS_EN
    // Stats: 3 req0 ops, 2 req1 ops, 7 stall cycles, then a forced wrap
    pulse_rst();
    #3;
    chk("stat_rst", 32'({stat_ops0, stat_ops1}), 32'd0);
    r0 = rsp_cnt;
    @(negedge clk); rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) s0_q.push_back('{op: 2'd0, a: 8'(i), b: 8'h01});
    for (int i = 0; i < 2; i++) s1_q.push_back('{op: 2'd2, a: 8'hFF, b: 8'(i)});
    wait_rsp_valid();
    repeat (6) @(negedge clk);
    @(negedge clk); rsp_ready = 1'b1;
    wait_rsp(r0 + 5);
    @(negedge clk); #3;
    chk("stat_ops0", 32'(stat_ops0), 32'd3);
    chk("stat_ops1", 32'(stat_ops1), 32'd2);
    chk("stat_stall", 32'(stat_stall), 32'd7);
    force u_dut.stat_ops0_q = 16'hFFFF;
    @(negedge clk);
    release u_dut.stat_ops0_q;
    r0 = rsp_cnt;
    s0_q.push_back('{op: 2'd0, a: 8'h01, b: 8'h01});
    wait_rsp(r0 + 1);
    @(negedge clk); #3;
    chk("stat_ops0_wrap", 32'(stat_ops0), 32'd0);
`endif

    repeat (3) @(negedge clk);
    #3;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("ready_rules", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_chk);
    $fatal(1, "simulation timeout");
  end

endmodule
